instr_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/branch_eval.sv | 29 ++
 rtl/instr_sequencer.sv | 102 ++++++++++
 tb/tb_instr_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer and its control-unit peers:
// opcode map, comparator condition codes, control-word bit positions, FSM encoding.
package cpu_pkg;

  // Opcode map (4-bit). All-ones is NOP/HALT.
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_LDI    = 4'h5;
  localparam logic [3:0] OP_LD     = 4'h6;
  localparam logic [3:0] OP_ST     = 4'h7;
  localparam logic [3:0] OP_CMP    = 4'h8;
  localparam logic [3:0] OP_MOV    = 4'h9;
  localparam logic [3:0] OP_SHR    = 4'hA;
  localparam logic [3:0] OP_JMP    = 4'hB;
  localparam logic [3:0] OP_JMP_EQ = 4'hC;
  localparam logic [3:0] OP_JMP_LT = 4'hD;
  localparam logic [3:0] OP_JMP_GT = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // Condition selector carried in ctrl[15:14].
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

  // Bit positions of the jump fields inside the control-unit word.
  localparam int JP      = 12;
  localparam int JPC     = 13;
  localparam int COMP_LO = 14;

  // Sequencer FSM encoding.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/branch_eval.sv
// Combinational jump decision: unconditional jump, or conditional jump whose
// condition is picked from the comparator flags by the comp selector.
module branch_eval
  import cpu_pkg::*;
(
  input  logic       jp,
  input  logic       jpc,
  input  logic [1:0] comp,
  input  logic       eq,
  input  logic       lt,
  input  logic       gt,
  output logic       taken
);

  logic cond;

  // Select the flag named by comp; the reserved code never satisfies a jump.
  always_comb begin
    cond = 1'b0;
    case (comp)
      CMP_EQ:  cond = eq;
      CMP_LT:  cond = lt;
      CMP_GT:  cond = gt;
      default: cond = 1'b0;
    endcase
    taken = jp | (jpc & cond);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequencing engine: walks the PC through a program ROM, presents each
// instruction to the control unit, waits one cycle for its registered controls,
// then resolves the next PC. Opcode all-ones halts the sequencer until reset.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 4,
  parameter int ARG_W  = 8   // must be >= ADDR_W: the operand doubles as jump target
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [OP_W+ARG_W-1:0] rom_data,
  output logic [OP_W-1:0]       op_code,
  output logic [ARG_W-1:0]      operand,
  input  logic                  ctrl_jp,
  input  logic                  ctrl_jpc,
  input  logic [1:0]            ctrl_comp,
  input  logic                  cmp_eq,
  input  logic                  cmp_lt,
  input  logic                  cmp_gt,
  output logic [ADDR_W-1:0]     pc,
  output logic                  instr_done,
  output logic                  halted
);

  // All-ones opcode: NOP to the control unit (no strobes), HALT when fetched.
  localparam logic [OP_W-1:0] NOP = '1;

  seq_state_t      state, next_state;
  logic [OP_W-1:0] rom_op;
  logic            taken;

  assign rom_op = rom_data[OP_W+ARG_W-1 -: OP_W];

  branch_eval u_branch (
    .jp    (ctrl_jp),
    .jpc   (ctrl_jpc),
    .comp  (ctrl_comp),
    .eq    (cmp_eq),
    .lt    (cmp_lt),
    .gt    (cmp_gt),
    .taken (taken)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= next_state;
  end

  // Next-state: run gates only the start of an instruction; HALT is absorbing.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  if (run) next_state = ST_LOAD;
      ST_LOAD:   next_state = (rom_op == NOP) ? ST_HALT : ST_SETTLE;
      ST_SETTLE: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_FETCH;
    endcase
  end

  // Status outputs are pure state decodes so they line up with the EXEC/HALT cycles.
  always_comb begin
    instr_done = (state == ST_EXEC);
    halted     = (state == ST_HALT);
  end

  // Datapath registers: address issue, instruction capture, PC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      rom_addr <= '0;
      op_code  <= NOP;
      operand  <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          rom_addr <= pc;
          op_code  <= NOP;
        end
        ST_LOAD: begin
          // A halt word must never reach the control unit as anything but NOP.
          op_code <= (rom_op == NOP) ? NOP : rom_op;
          operand <= rom_data[ARG_W-1:0];
        end
        ST_EXEC: begin
          // Drop back to NOP so control strobes last a single control-unit cycle.
          op_code <= NOP;
          if (taken) pc <= operand[ADDR_W-1:0];
          else       pc <= pc + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios followed by a
// randomized instruction stream, checked against a per-instruction PC model.
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [7:0]  rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  op_code;
  logic [7:0]  operand;
  logic        ctrl_jp, ctrl_jpc;
  logic [1:0]  ctrl_comp;
  logic        cmp_eq, cmp_lt, cmp_gt;
  logic [7:0]  pc;
  logic        instr_done, halted;

  logic [11:0] rom [256];
  logic [7:0]  pc_m;
  int          ncomp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  // ROM model: the registered rom_addr is the one-cycle read latency.
  assign rom_data = rom[rom_addr];

  instr_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .op_code(op_code), .operand(operand), .ctrl_jp(ctrl_jp), .ctrl_jpc(ctrl_jpc),
    .ctrl_comp(ctrl_comp), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_gt(cmp_gt),
    .pc(pc), .instr_done(instr_done), .halted(halted)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction from FETCH back to the following FETCH, 4 cycles.
  task automatic instr(input logic [11:0] w, input logic jp, input logic jpc,
                       input logic [1:0] comp, input logic eq, input logic lt,
                       input logic gt, input logic drop_run);
    logic cond;
    rom[pc_m] = w;
    ctrl_jp = jp; ctrl_jpc = jpc; ctrl_comp = comp;
    cmp_eq = eq; cmp_lt = lt; cmp_gt = gt;
    run = 1'b1;
    step();                                   // LOAD
    chk("load_addr", 16'(rom_addr), 16'(pc_m));
    chk("load_done", 16'(instr_done), 16'(0));
    step();                                   // SETTLE or HALT
    if (w[11:8] == 4'hF) begin
      chk("halt_flag", 16'(halted), 16'(1));
      chk("halt_op",   16'(op_code), 16'hF);
      chk("halt_pc",   16'(pc), 16'(pc_m));
      chk("halt_done", 16'(instr_done), 16'(0));
      return;
    end
    chk("settle_op",  16'(op_code), 16'(w[11:8]));
    chk("settle_arg", 16'(operand), 16'(w[7:0]));
    chk("settle_hlt", 16'(halted), 16'(0));
    chk("settle_done", 16'(instr_done), 16'(0));
    if (drop_run) run = 1'b0;
    step();                                   // EXEC
    chk("exec_done", 16'(instr_done), 16'(1));
    chk("exec_op",   16'(op_code), 16'(w[11:8]));
    case (comp)
      2'b00:   cond = eq;
      2'b01:   cond = lt;
      2'b10:   cond = gt;
      default: cond = 1'b0;
    endcase
    pc_m = (jp || (jpc && cond)) ? w[7:0] : 8'(pc_m + 8'd1);
    step();                                   // FETCH
    chk("next_pc",   16'(pc), 16'(pc_m));
    chk("next_done", 16'(instr_done), 16'(0));
    chk("next_op",   16'(op_code), 16'hF);
  endtask

  // Idle in FETCH with run low: nothing advances, NOP presented.
  task automatic idle(input int n);
    run = 1'b0;
    repeat (n) begin
      step();
      chk("idle_addr", 16'(rom_addr), 16'(pc_m));
      chk("idle_op",   16'(op_code), 16'hF);
      chk("idle_done", 16'(instr_done), 16'(0));
      chk("idle_pc",   16'(pc), 16'(pc_m));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rst = 1'b1; run = 1'b0;
    ctrl_jp = 0; ctrl_jpc = 0; ctrl_comp = 0; cmp_eq = 0; cmp_lt = 0; cmp_gt = 0;
    step(); step();
    chk("rst_pc", 16'(pc), 16'(0));
    chk("rst_addr", 16'(rom_addr), 16'(0));
    chk("rst_op", 16'(op_code), 16'hF);
    chk("rst_arg", 16'(operand), 16'(0));
    chk("rst_done", 16'(instr_done), 16'(0));
    chk("rst_halt", 16'(halted), 16'(0));
    rst = 1'b0;
    pc_m = 8'h00;

    // Straight-line, unconditional and conditional jumps.
    instr({OP_ADD, 8'h12}, 0, 0, 2'b00, 0, 0, 0, 0);          // 0 -> 1
    instr({OP_SUB, 8'h34}, 0, 0, 2'b00, 0, 0, 0, 0);          // 1 -> 2
    instr({OP_JMP, 8'h40}, 1, 0, 2'b00, 0, 0, 0, 0);          // 2 -> 40
    instr({OP_JMP, 8'h05}, 1, 0, 2'b00, 0, 0, 0, 0);          // 40 -> 5
    instr({OP_JMP_LT, 8'h10}, 0, 1, 2'b01, 0, 1, 0, 0);       // 5 -> 10
    instr({OP_JMP, 8'h05}, 1, 0, 2'b00, 0, 0, 0, 0);          // 10 -> 5
    instr({OP_JMP_LT, 8'h10}, 0, 1, 2'b01, 0, 0, 1, 0);       // 5 -> 6
    instr({OP_JMP, 8'h05}, 1, 0, 2'b00, 0, 0, 0, 0);          // 6 -> 5
    instr({OP_JMP_LT, 8'h10}, 0, 1, 2'b11, 1, 1, 1, 0);       // reserved: 5 -> 6
    instr({OP_JMP_EQ, 8'h30}, 1, 1, 2'b00, 0, 0, 0, 0);       // jp dominates: 6 -> 30
    instr({OP_JMP, 8'h30}, 1, 0, 2'b00, 0, 0, 0, 0);          // self-loop 30 -> 30
    instr({OP_JMP, 8'hFF}, 1, 0, 2'b00, 0, 0, 0, 0);          // 30 -> FF
    instr({OP_ADD, 8'h00}, 0, 0, 2'b00, 0, 0, 0, 0);          // FF wraps -> 0
    instr({OP_ADD, 8'h01}, 0, 0, 2'b00, 0, 0, 0, 1);          // run drops mid-instruction
    idle(3);
    instr({OP_JMP, 8'h03}, 1, 0, 2'b00, 0, 0, 0, 0);          // 1 -> 3

    // Halt is sticky until reset.
    instr({OP_HALT, 8'h77}, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (3) begin
      step();
      chk("hold_halt", 16'(halted), 16'(1));
      chk("hold_pc", 16'(pc), 16'(3));
      chk("hold_op", 16'(op_code), 16'hF);
      chk("hold_done", 16'(instr_done), 16'(0));
    end
    rst = 1'b1; step(); rst = 1'b0;
    chk("unhalt_pc", 16'(pc), 16'(0));
    chk("unhalt_flag", 16'(halted), 16'(0));
    pc_m = 8'h00;

    // Randomized instruction stream.
    repeat (60) begin
      logic [11:0] w;
      logic        drop;
      w    = {4'($urandom_range(0, 14)), 8'($urandom)};
      drop = ($urandom_range(0, 3) == 0);
      instr(w, 1'($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), drop);
      if (drop) idle($urandom_range(1, 3));
    end

    // Reset during SETTLE discards the in-flight instruction.
    rom[pc_m] = {OP_JMP, 8'h99};
    ctrl_jp = 1'b1; run = 1'b1;
    step(); step();
    chk("mid_settle_op", 16'(op_code), 16'(OP_JMP));
    rst = 1'b1; step(); rst = 1'b0; run = 1'b0;
    chk("mid_rst_pc", 16'(pc), 16'(0));
    chk("mid_rst_op", 16'(op_code), 16'hF);
    chk("mid_rst_done", 16'(instr_done), 16'(0));
    chk("mid_rst_halt", 16'(halted), 16'(0));
    pc_m = 8'h00;
    step();
    chk("mid_rst_fetch_pc", 16'(pc), 16'(0));
    chk("mid_rst_fetch_done", 16'(instr_done), 16'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
